uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, giving the width of the baud divisor.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; asynchronous, active-high.
REQ-004 The block SHALL have port tx_data, input, 8 bits, the byte to transmit.
REQ-005 The block SHALL have port tx_valid, input, 1 bit, meaning the producer offers tx_data.
REQ-006 The block SHALL have port tx_ready, output, 1 bit, meaning the controller can accept a byte.
REQ-007 The block SHALL have port odd_parity, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-008 The block SHALL have port baud_div, input, DIV_W bits, the clock cycles per bit.
REQ-009 The block SHALL have port ld, output, 1 bit, the load strobe to the downstream 11-bit shift register.
REQ-010 The block SHALL have port sh, output, 1 bit, the shift strobe to the shift register.
REQ-011 The block SHALL have port sdi, output, 1 bit, the serial fill bit to the shift register; constant 1.
REQ-012 The block SHALL have port din, output, 11 bits, the frame to the shift register.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a frame is in flight.
REQ-014 The block SHALL have port tx_done, output, 1 bit, a one-cycle pulse at frame end.

Function
REQ-015 The state machine SHALL have exactly two states, IDLE and SEND.
REQ-016 tx_ready SHALL be 1 in IDLE and 0 in SEND and during rst.
REQ-017 The accept condition SHALL be tx_valid & tx_ready.
REQ-018 ld SHALL be combinational and equal to accept, so the shift register loads on the acceptance edge.
REQ-019 din SHALL be combinational: din[0]=0 (start), din[8:1]=tx_data (LSB at din[1]), din[9]=parity/pad, din[10]=1 (stop).
REQ-020 On accept, the block SHALL latch baud_div (0 treated as 1) into div_q, clear baud counter and bit counter, and enter SEND.
REQ-021 In SEND, the baud counter SHALL increment each cycle; sh SHALL be combinational 1 when the counter equals div_q-1, after which the counter wraps to 0.
REQ-022 The bit counter SHALL count sh pulses; on the 11th sh, state SHALL return to IDLE.
REQ-023 tx_done SHALL be a registered pulse, high for the one cycle after the 11th sh edge.
REQ-024 The total time from the acceptance edge to the 11th sh edge SHALL be 11*div_q cycles.
REQ-025 busy SHALL be 1 exactly in SEND.
REQ-026 ld and sh SHALL never be high in the same cycle; sh SHALL be 0 in IDLE.
REQ-027 Changes to baud_div or tx_data during SEND SHALL have no effect on the frame in flight.
REQ-028 Back-to-back operation: tx_ready SHALL be 1 in the tx_done cycle, and a byte accepted there SHALL start the next frame with no further gap.

Reset
REQ-029 On rst, state SHALL go to IDLE with counters 0, tx_done=0, busy=0, div_q=1, ld=0, sh=0; tx_ready SHALL be 1 after rst deasserts.
REQ-030 A rst mid-frame SHALL abort the frame without a tx_done pulse; the downstream register's own reset returns the line high.

Configuration
REQ-031 The macro UART_TX_PARITY_EN SHALL select parity generation.
REQ-032 With UART_TX_PARITY_EN defined, din[9] SHALL be ^tx_data when odd_parity=0, and ~^tx_data when odd_parity=1.
REQ-033 Without UART_TX_PARITY_EN, din[9] SHALL be 1 (second stop bit) and odd_parity SHALL be ignored; all timing SHALL be unchanged.

Verification
REQ-034 Scenario: baud_div=4, tx_data=8'hA5, parity enabled, odd_parity=0 -> din=11'b1_0_10100101_0, sh every 4 cycles, tx_done 44 cycles after accept.
REQ-035 Scenario: tx_data=8'h07, odd_parity=1, parity enabled -> din[9]=0; with the macro undefined -> din[9]=1.
REQ-036 Scenario: baud_div=0 -> sh every cycle, tx_done 11 cycles after accept.
REQ-037 Scenario: tx_valid held high for 2 bytes (8'h55, 8'hAA), baud_div=3 -> second ld coincides with the tx_done cycle, and tx_ready=0 otherwise during SEND.
REQ-038 Scenario: rst asserted after the 5th sh -> state IDLE, busy=0, no tx_done pulse, and the next accept produces a full 11-bit frame.
REQ-039 Scenario: baud_div changed from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits, and the next frame uses 8.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller driving an external 11-bit shift register
//
// Accepts a byte on a valid/ready handshake, presents the framed word on din
// with a load strobe, then issues one shift strobe per bit period until all
// 11 frame bits have gone out.
//
// Build option: define UART_TX_PARITY_EN to put a parity bit in din[9];
// otherwise din[9] is a second stop bit and odd_parity has no effect.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tx_data     byte to transmit
//   tx_valid    producer offers tx_data
//   tx_ready    controller can accept a byte (IDLE and not in reset)
//   odd_parity  1 = odd parity, 0 = even parity
//   baud_div    clock cycles per bit (0 treated as 1)
//   ld          load strobe to the shift register (equals accept)
//   sh          shift strobe to the shift register
//   sdi         serial fill bit, constant 1
//   din         frame: {stop, parity/pad, tx_data, start}
//   busy        a frame is in flight
//   tx_done     one-cycle pulse after the last shift

module uart_tx_ctrl #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             odd_parity,
    input  logic [DIV_W-1:0] baud_div,
    output logic             ld,
    output logic             sh,
    output logic             sdi,
    output logic [10:0]      din,
    output logic             busy,
    output logic             tx_done
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic             accept;
    logic             last_bit;
    logic             parity_bit;

`ifdef UART_TX_PARITY_EN
    assign parity_bit = odd_parity ? ~^tx_data : ^tx_data;
`else
    // Second stop bit; the OR keeps odd_parity referenced without affecting din.
    assign parity_bit = 1'b1 | odd_parity;
`endif

    assign din = {1'b1, parity_bit, tx_data, 1'b0};
    assign sdi = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        accept     = 1'b0;
        ld         = 1'b0;
        sh         = 1'b0;
        busy       = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                // Ready is masked by rst so nothing is accepted while reset is held.
                tx_ready = ~rst;
                accept   = tx_valid & ~rst;
                ld       = accept;
                if (accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                busy     = 1'b1;
                sh       = (baud_cnt == div_q - DIV_ONE);
                last_bit = sh && (bit_cnt == 4'd10);
                if (last_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= DIV_ONE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= last_bit;
            if (accept) begin
                // Divisor is captured here so later baud_div changes leave this frame alone.
                div_q    <= (baud_div == '0) ? DIV_ONE : baud_div;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (sh) begin
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else if (busy) begin
                baud_cnt <= baud_cnt + DIV_ONE;
            end
        end
    end

endmodule
